fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 79 +++++++
 tb/tb_fifo_wr_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-locked round-robin arbiter that merges NUM_REQ sources onto one FIFO write port.
// A grant is held from the first beat of a packet until its last beat is written.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int LOGIC_SIZE = 8
) (
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic [NUM_REQ-1:0]                  i_valid,
   input  logic [NUM_REQ-1:0][LOGIC_SIZE-1:0]  i_data,
   input  logic [NUM_REQ-1:0]                  i_last,
   output logic [NUM_REQ-1:0]                  o_ready,
   input  logic                                i_fifo_full,
   output logic                                o_fifo_wr,
   output logic [LOGIC_SIZE-1:0]               o_fifo_wdata,
   output logic [NUM_REQ-1:0]                  o_grant,
   output logic                                o_busy
);
   localparam int PW = $clog2(NUM_REQ);
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t state, state_nxt;
   logic [PW-1:0] rr_ptr, rr_nxt, g_idx;
   logic [NUM_REQ-1:0] grant_nxt, pick;
   logic found, g_valid, g_last;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         o_grant <= '0;
      end else begin
         state   <= state_nxt;
         rr_ptr  <= rr_nxt;
         o_grant <= grant_nxt;
      end
   end
   // Round-robin pick: first pass covers rr_ptr..N-1, second pass wraps to the lowest index.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int n = 0; n < NUM_REQ; n++) begin
         if (!found && i_valid[n] && PW'(n) >= rr_ptr) begin
            pick[n] = 1'b1;
            found   = 1'b1;
         end
      end
      for (int n = 0; n < NUM_REQ; n++) begin
         if (!found && i_valid[n]) begin
            pick[n] = 1'b1;
            found   = 1'b1;
         end
      end
   end
   // o_grant is zero outside LOCKED, so masking by it also forces the IDLE outputs to zero.
   always_comb begin
      g_idx        = '0;
      o_fifo_wdata = '0;
      for (int n = 0; n < NUM_REQ; n++) begin
         g_idx        = o_grant[n] ? PW'(n) : g_idx;
         o_fifo_wdata = o_fifo_wdata | (o_grant[n] ? i_data[n] : '0);
      end
      g_valid   = |(i_valid & o_grant);
      g_last    = |(i_last & o_grant);
      o_ready   = i_fifo_full ? '0 : o_grant;
      o_fifo_wr = g_valid && !i_fifo_full;
      o_busy    = state == LOCKED;
      state_nxt = state;
      grant_nxt = o_grant;
      rr_nxt    = rr_ptr;
      if (state == IDLE && found) begin
         state_nxt = LOCKED;
         grant_nxt = pick;
      end
      if (state == LOCKED && o_fifo_wr && g_last) begin
         state_nxt = IDLE;
         grant_nxt = '0;
         rr_nxt    = (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: vector table, directed corner sequences and a randomized run against a
// queue-free round-robin reference model with per-source word sequence scoreboarding.
module tb_fifo_wr_arbiter;
   localparam int N = 4;
   localparam int W = 8;
   logic i_clk = 1'b0;
   logic i_rst_n = 1'b1;
   logic [N-1:0] i_valid, i_last, o_ready, o_grant;
   logic [N-1:0][W-1:0] i_data;
   logic i_fifo_full, o_fifo_wr, o_busy;
   logic [W-1:0] o_fifo_wdata;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [N-1:0] v, l;
      logic         f;
      logic [N-1:0] g, r;
      logic         wr, busy;
      logic [W-1:0] wd;
   } vec_t;

   fifo_wr_arbiter #(.NUM_REQ(N), .LOGIC_SIZE(W)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
      .o_ready(o_ready), .i_fifo_full(i_fifo_full), .o_fifo_wr(o_fifo_wr),
      .o_fifo_wdata(o_fifo_wdata), .o_grant(o_grant), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
      i_valid = v;
      i_last = l;
      i_fifo_full = f;
      #2;
   endtask

   task automatic next_cycle();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      drive('0, '0, 1'b0);
      i_rst_n = 1'b0;
      next_cycle();
      i_rst_n = 1'b1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_grant"}, 32'(o_grant), 0);
      check({tag, "_ready"}, 32'(o_ready), 0);
      check({tag, "_wr"}, 32'(o_fifo_wr), 0);
      check({tag, "_busy"}, 32'(o_busy), 0);
      check({tag, "_wdata"}, 32'(o_fifo_wdata), 0);
   endtask

   vec_t tbl[16];
   int seq[N];
   logic [N-1:0] exp_g_seq[10];
   bit m_busy;
   int m_g, m_rr, idx;
   logic [N-1:0] e_g, e_r;
   logic e_wr;

   initial begin
      for (int n = 0; n < N; n++) i_data[n] = W'(8'hA0 + n);
      i_valid = '0;
      i_last = '0;
      i_fifo_full = 1'b0;
      #1 i_rst_n = 1'b0;
      #1 check_zero("reset");
      drive('1, '1, 1'b0);
      next_cycle();
      check_zero("reset_held");
      drive('0, '0, 1'b0);
      i_rst_n = 1'b1;
      next_cycle();

      // v l f | grant ready wr busy wdata
      tbl[0]  = '{4'h5, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00};
      tbl[1]  = '{4'h5, 4'h0, 1'b0, 4'h1, 4'h1, 1'b1, 1'b1, 8'hA0};
      tbl[2]  = '{4'h5, 4'h0, 1'b0, 4'h1, 4'h1, 1'b1, 1'b1, 8'hA0};
      tbl[3]  = '{4'h5, 4'h1, 1'b0, 4'h1, 4'h1, 1'b1, 1'b1, 8'hA0};
      tbl[4]  = '{4'h4, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00};
      tbl[5]  = '{4'h4, 4'h4, 1'b1, 4'h4, 4'h0, 1'b0, 1'b1, 8'h00};
      tbl[6]  = '{4'h4, 4'h4, 1'b0, 4'h4, 4'h4, 1'b1, 1'b1, 8'hA2};
      tbl[7]  = '{4'h1, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00};
      tbl[8]  = '{4'h0, 4'h0, 1'b0, 4'h1, 4'h1, 1'b0, 1'b1, 8'h00};
      tbl[9]  = '{4'h3, 4'h3, 1'b0, 4'h1, 4'h1, 1'b1, 1'b1, 8'hA0};
      tbl[10] = '{4'h3, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00};
      tbl[11] = '{4'h2, 4'h2, 1'b0, 4'h2, 4'h2, 1'b1, 1'b1, 8'hA1};
      tbl[12] = '{4'h9, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00};
      tbl[13] = '{4'h8, 4'h8, 1'b0, 4'h8, 4'h8, 1'b1, 1'b1, 8'hA3};
      tbl[14] = '{4'h9, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00};
      tbl[15] = '{4'h9, 4'h1, 1'b0, 4'h1, 4'h1, 1'b1, 1'b1, 8'hA0};
      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].v, tbl[i].l, tbl[i].f);
         check($sformatf("tbl%0d_grant", i), 32'(o_grant), 32'(tbl[i].g));
         check($sformatf("tbl%0d_ready", i), 32'(o_ready), 32'(tbl[i].r));
         check($sformatf("tbl%0d_wr", i), 32'(o_fifo_wr), 32'(tbl[i].wr));
         check($sformatf("tbl%0d_busy", i), 32'(o_busy), 32'(tbl[i].busy));
         if (tbl[i].wr || !tbl[i].busy)
            check($sformatf("tbl%0d_wdata", i), 32'(o_fifo_wdata), 32'(tbl[i].wd));
         next_cycle();
      end

      // All sources stream single-beat packets: grants 0,1,2,3,0 with one idle cycle between.
      do_reset();
      exp_g_seq = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
      for (int i = 0; i < 10; i++) begin
         drive('1, '1, 1'b0);
         check($sformatf("stream%0d_grant", i), 32'(o_grant), 32'(exp_g_seq[i]));
         check($sformatf("stream%0d_wr", i), 32'(o_fifo_wr), 32'(exp_g_seq[i] != 0));
         next_cycle();
      end

      // FIFO full for 5 cycles mid-packet, then granted source stalls while source 1 waits.
      do_reset();
      i_data[0] = 8'h10;
      drive(4'h1, 4'h0, 1'b0);
      next_cycle();
      drive(4'h1, 4'h0, 1'b0);
      check("full_pre_wdata", 32'(o_fifo_wdata), 32'h10);
      next_cycle();
      i_data[0] = 8'h11;
      for (int i = 0; i < 5; i++) begin
         drive(4'h3, 4'h0, 1'b1);
         check($sformatf("full%0d_wr", i), 32'(o_fifo_wr), 0);
         check($sformatf("full%0d_ready", i), 32'(o_ready), 0);
         check($sformatf("full%0d_grant", i), 32'(o_grant), 1);
         next_cycle();
      end
      for (int i = 0; i < 3; i++) begin
         drive(4'h2, 4'h0, 1'b0);
         check($sformatf("stall%0d_grant", i), 32'(o_grant), 1);
         check($sformatf("stall%0d_ready", i), 32'(o_ready), 1);
         check($sformatf("stall%0d_wr", i), 32'(o_fifo_wr), 0);
         next_cycle();
      end
      drive(4'h3, 4'h1, 1'b0);
      check("full_post_wr", 32'(o_fifo_wr), 1);
      check("full_post_wdata", 32'(o_fifo_wdata), 32'h11);
      next_cycle();
      drive(4'h2, 4'h0, 1'b0);
      check("full_post_idle", 32'(o_busy), 0);
      next_cycle();
      drive(4'h2, 4'h2, 1'b0);
      check("full_next_grant", 32'(o_grant), 2);
      next_cycle();

      // Asynchronous reset during the second beat of source 3.
      do_reset();
      for (int n = 0; n < N; n++) i_data[n] = W'(8'hA0 + n);
      drive(4'h8, 4'h0, 1'b0);
      next_cycle();
      drive(4'h8, 4'h0, 1'b0);
      check("rst_beat1_grant", 32'(o_grant), 8);
      next_cycle();
      drive(4'h9, 4'h0, 1'b0);
      check("rst_beat2_wr", 32'(o_fifo_wr), 1);
      i_rst_n = 1'b0;
      #1 check_zero("async_rst");
      next_cycle();
      i_rst_n = 1'b1;
      drive(4'h9, 4'h0, 1'b0);
      check_zero("post_rst_idle");
      next_cycle();
      drive(4'h9, 4'h0, 1'b0);
      check("post_rst_grant", 32'(o_grant), 1);
      next_cycle();

      // Randomized run against the reference model.
      do_reset();
      m_busy = 0;
      m_g = 0;
      m_rr = 0;
      for (int n = 0; n < N; n++) seq[n] = 0;
      for (int c = 0; c < 600; c++) begin
         for (int n = 0; n < N; n++) begin
            i_data[n] = {2'(n), 6'(seq[n])};
            i_valid[n] = $urandom_range(0, 3) != 0;
            i_last[n] = $urandom_range(0, 2) == 0;
         end
         i_fifo_full = $urandom_range(0, 3) == 0;
         #2;
         e_g = m_busy ? N'(1 << m_g) : '0;
         e_r = (m_busy && !i_fifo_full) ? e_g : '0;
         e_wr = m_busy && i_valid[m_g] && !i_fifo_full;
         check("rnd_grant", 32'(o_grant), 32'(e_g));
         check("rnd_ready", 32'(o_ready), 32'(e_r));
         check("rnd_wr", 32'(o_fifo_wr), 32'(e_wr));
         check("rnd_busy", 32'(o_busy), 32'(m_busy));
         if (e_wr) check("rnd_wdata", 32'(o_fifo_wdata), 32'({2'(m_g), 6'(seq[m_g])}));
         if (!m_busy) check("rnd_idle_wdata", 32'(o_fifo_wdata), 0);
         if (m_busy) begin
            if (e_wr) begin
               seq[m_g]++;
               if (i_last[m_g]) begin
                  m_busy = 0;
                  m_rr = (m_g + 1) % N;
               end
            end
         end else begin
            for (int k = N - 1; k >= 0; k--) begin
               idx = (m_rr + k) % N;
               if (i_valid[idx]) begin
                  m_g = idx;
                  m_busy = 1;
               end
            end
         end
         next_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
